keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_PERIOD, default 100000: clock cycles each keypad row is driven; legal range >= 4.
REQ-002 Parameter DEBOUNCE_FRAMES, default 8: consecutive identical full-scan frames needed to accept a press or a release; legal range >= 1.
REQ-003 clk_in  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 rst_in  input  1  synchronous, active-high reset.
REQ-005 col_in  input  4  keypad columns, active-low (pulled up), asynchronous to clk_in.
REQ-006 clear_in  input  1  synchronous clear of val_out.
REQ-007 row_out  output  4  keypad row drive, active-low, exactly one bit low at all times.
REQ-008 key_code  output  4  hex code of the last accepted key.
REQ-009 key_valid  output  1  one-cycle pulse per accepted press.
REQ-010 key_held  output  1  high from acceptance of a press until acceptance of its release.
REQ-011 val_out  output  32  last eight accepted key codes, newest in [3:0]; drives the display controller's val_in directly.

Function
REQ-012 col_in SHALL pass through a two-flop synchronizer before any use.
REQ-013 A dwell counter SHALL count 0..SCAN_PERIOD-1 and wrap; at count SCAN_PERIOD-1 the synchronized columns are sampled for the active row, and the active row advances 0->1->2->3->0 on the following edge.
REQ-014 Row r active SHALL mean row_out[r]=0 and all other bits 1.
REQ-015 Samples from the four rows SHALL form a 16-bit frame map (bit 4*r+c = key at row r, column c pressed); a frame completes when row 3 is sampled.
REQ-016 Frame classification: EMPTY (no bits set), SINGLE (exactly one bit set; position gives the key), MULTI (two or more bits set).
REQ-017 Position-to-code map: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = E(*),0,F(#),D.
REQ-018 FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB; it is evaluated only on frame completion, and the debounce counter is cleared on every state change.
REQ-019 IDLE: SINGLE -> PRESS_DB with candidate latched and count=1; EMPTY or MULTI -> stay.
REQ-020 PRESS_DB: SINGLE equal to candidate -> count+1; on reaching DEBOUNCE_FRAMES -> HELD; a different SINGLE restarts with the new candidate at count=1; EMPTY or MULTI -> IDLE.
REQ-021 With DEBOUNCE_FRAMES=1, IDLE SHALL go straight to HELD on the first SINGLE frame.
REQ-022 On entry to HELD: key_code <= candidate and key_valid high for exactly that one cycle (frame-completion cycle + 1); key_held <= 1.
REQ-023 HELD: EMPTY -> RELEASE_DB with count=1; SINGLE or MULTI -> stay; no repeat pulses.
REQ-024 RELEASE_DB: EMPTY -> count+1, and on reaching DEBOUNCE_FRAMES -> IDLE with key_held <= 0; any non-EMPTY frame -> HELD.
REQ-025 On each key_valid, val_out <= {val_out[27:0], key_code}; the oldest nibble is dropped.
REQ-026 clear_in SHALL set val_out to 0; if it coincides with a shift, the clear wins, while key_valid and key_code behave normally.

Reset
REQ-027 On rst_in: row_out=4'b1110, dwell counter 0, frame map 0, state IDLE, debounce count 0, key_code 0, key_valid 0, key_held 0, val_out 0, synchronizer flops 1.
REQ-028 Reset mid-debounce or mid-frame SHALL discard all partial state, with no key_valid pulse.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the frame-class enum, and the 16-entry position-to-code table.
REQ-030 One sub-module, keypad_frame_classifier (combinational: 16-bit map in -> class plus 4-bit position out), SHALL be used; everything else stays in keypad_scanner.

Verification (SCAN_PERIOD=4, DEBOUNCE_FRAMES=2, so a frame is 16 cycles)
REQ-031 Assert rst_in for 2 cycles -> row_out=1110 and all other outputs 0; row_out steps to 1101 after 4 cycles.
REQ-032 Press row1/col2 for 5 frames -> exactly one key_valid with key_code=6, val_out=0x00000006, key_held=1; release for 2 frames -> key_held=0.
REQ-033 Alternate pressing key 5 for one frame and releasing for one frame, 6 times -> no key_valid.
REQ-034 Hold keys 1 and 2 together for 6 frames -> no key_valid, state stays IDLE.
REQ-035 Enter keys 1,2,3,A,B,C,D,E,0 with clean releases -> val_out=0x23ABCDE0.
REQ-036 Pulse clear_in on the key_valid cycle of key 9 -> val_out=0 and key_code=9; assert rst_in during PRESS_DB -> no pulse follows.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared types and the key position-to-code table
// for the 4x4 keypad scanner.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_RELEASE_DB
  } kp_state_e;

  typedef enum logic [1:0] {
    FR_EMPTY,
    FR_SINGLE,
    FR_MULTI
  } frame_class_e;

  // Index is 4*row+col; entry 0 sits in the low nibble.
  localparam logic [15:0][3:0] POS_CODE = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] pos_to_code(input logic [3:0] pos);
    return POS_CODE[pos];
  endfunction

endpackage

// File: rtl/keypad_frame_classifier.sv
// Classifies a 16-bit keypad frame as empty, single or multi,
// and reports the position of the (last) set bit.
module keypad_frame_classifier
  import keypad_scanner_pkg::*;
(
  input  logic [15:0]  map_in,
  output frame_class_e cls_out,
  output logic [3:0]   pos_out
);

  logic [4:0] ones;

  always_comb begin
    ones    = '0;
    pos_out = '0;
    for (int i = 0; i < 16; i++) begin
      if (map_in[i]) begin
        ones    = ones + 5'd1;
        pos_out = 4'(i);
      end
    end
    if (ones == 5'd0)
      cls_out = FR_EMPTY;
    else if (ones == 5'd1)
      cls_out = FR_SINGLE;
    else
      cls_out = FR_MULTI;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with frame-level debounce and
// an eight-digit shift history for the display.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_PERIOD     = 100000,
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [3:0]  col_in,
  input  logic        clear_in,
  output logic [3:0]  row_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [31:0] val_out
);

  localparam int CW = $clog2(SCAN_PERIOD);
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_PERIOD - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_FRAMES);
  localparam logic [DW-1:0] DB_ONE     = DW'(1);

  logic [3:0]    col_s1_q, col_s1_d;
  logic [3:0]    col_s2_q, col_s2_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [1:0]    row_q, row_d;
  logic [15:0]   map_q, map_d;
  kp_state_e     state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic [31:0]   val_q, val_d;

  logic [15:0]   frame_full;
  frame_class_e  cls;
  logic [3:0]    pos;
  logic          sample;
  logic          frame_done;
  logic [DW-1:0] cnt_inc;
  logic          go_held;
  logic [3:0]    acc_pos;

  // Overlay the row being sampled so the classifier sees the whole frame
  always_comb begin
    frame_full = map_q;
    frame_full[{row_q, 2'b00} +: 4] = ~col_s2_q;
  end

  keypad_frame_classifier u_cls (
    .map_in  (frame_full),
    .cls_out (cls),
    .pos_out (pos)
  );

  always_comb begin
    col_s1_d   = col_in;
    col_s2_d   = col_s1_q;
    sample     = (dwell_q == DWELL_LAST);
    frame_done = sample && (row_q == 2'd3);
    dwell_d    = sample ? '0 : dwell_q + 1'b1;
    row_d      = sample ? row_q + 2'd1 : row_q;
    map_d      = sample ? frame_full : map_q;
    cnt_inc    = cnt_q + 1'b1;
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    code_d     = code_q;
    held_d     = held_q;
    valid_d    = 1'b0;
    go_held    = 1'b0;
    acc_pos    = cand_q;

    if (frame_done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (cls == FR_SINGLE) begin
            cand_d  = pos;
            acc_pos = pos;
            if (DEBOUNCE_FRAMES == 1) begin
              go_held = 1'b1;
            end else begin
              state_d = ST_PRESS_DB;
              cnt_d   = DB_ONE;
            end
          end
        end
        ST_PRESS_DB: begin
          if (cls != FR_SINGLE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (pos != cand_q) begin
            cand_d = pos;
            cnt_d  = DB_ONE;
          end else if (cnt_inc == DB_LAST) begin
            go_held = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_HELD: begin
          if (cls == FR_EMPTY) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
              held_d  = 1'b0;
            end else begin
              state_d = ST_RELEASE_DB;
              cnt_d   = DB_ONE;
            end
          end
        end
        ST_RELEASE_DB: begin
          if (cls != FR_EMPTY) begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end else if (cnt_inc == DB_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            held_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (go_held) begin
      state_d = ST_HELD;
      cnt_d   = '0;
      valid_d = 1'b1;
      code_d  = pos_to_code(acc_pos);
      held_d  = 1'b1;
    end

    // Clear beats a coincident shift
    if (clear_in)
      val_d = '0;
    else if (valid_q)
      val_d = {val_q[27:0], code_q};
    else
      val_d = val_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
      dwell_q  <= '0;
      row_q    <= '0;
      map_q    <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
      val_q    <= '0;
    end else begin
      col_s1_q <= col_s1_d;
      col_s2_q <= col_s2_d;
      dwell_q  <= dwell_d;
      row_q    <= row_d;
      map_q    <= map_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      held_q   <= held_d;
      val_q    <= val_d;
    end
  end

  assign row_out   = ~(4'b0001 << row_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign val_out   = val_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a simulated keypad matrix,
// a frame-level debounce model, and a decoupled output monitor.
module tb_keypad_scanner;
  import keypad_scanner_pkg::*;

  localparam int SP    = 4;
  localparam int DF    = 2;
  localparam int FRAME = 4 * SP;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        clear_in = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [31:0] val_out;

  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;

  logic [3:0]  exp_q[$];
  logic [31:0] exp_val = '0;
  bit          pend = 1'b0;
  logic [3:0]  mon_e;

  logic [15:0] m_last = '0;
  int          m_run = 0;
  bit          m_held = 1'b0;

  logic [3:0] ktab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scanner #(
    .SCAN_PERIOD     (SP),
    .DEBOUNCE_FRAMES (DF)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst_in),
    .col_in    (col_in),
    .clear_in  (clear_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .val_out   (val_out)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key shorts its column to the driven row
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && pressed[4*r+c]) col_in[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A press is accepted when DF identical single-key frames run back to
  // back while no key is held; a release needs DF empty frames in a row.
  task automatic model_step(input logic [15:0] m, output bit acc);
    acc = 1'b0;
    if (m_run > 0 && m == m_last) m_run++;
    else begin
      m_last = m;
      m_run  = 1;
    end
    if (!m_held && $countones(m) == 1 && m_run == DF) begin
      m_held = 1'b1;
      acc    = 1'b1;
      for (int i = 0; i < 16; i++)
        if (m[i]) exp_q.push_back(ktab[i]);
    end else if (m_held && m == 16'h0 && m_run == DF) begin
      m_held = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] m, input bit clr_on_acc);
    bit acc;
    pressed = m;
    model_step(m, acc);
    repeat (FRAME) begin
      @(posedge clk);
      #1;
      clear_in = 1'b0;
    end
    check("key_held", {31'b0, key_held}, {31'b0, m_held});
    if (acc && clr_on_acc) clear_in = 1'b1;
  endtask

  task automatic do_reset();
    rst_in  = 1'b1;
    pressed = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b0;
    exp_q.delete();
    m_run  = 0;
    m_held = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_in) begin
      exp_val = '0;
      pend    = 1'b0;
    end else begin
      if (pend) begin
        check("val_out", val_out, exp_val);
        pend = 1'b0;
      end
      if (key_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL key_valid: got pulse code %h expected none", key_code);
          if (clear_in) begin
            exp_val = '0;
            pend    = 1'b1;
          end
        end else begin
          mon_e = exp_q.pop_front();
          check("key_code", {28'b0, key_code}, {28'b0, mon_e});
          exp_val = clear_in ? 32'h0 : {exp_val[27:0], mon_e};
          pend    = 1'b1;
        end
      end else if (clear_in) begin
        exp_val = '0;
        pend    = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    bit acc;
    int kpos [9] = '{0, 1, 2, 3, 7, 11, 15, 12, 13};
    logic [15:0] one = 16'h1;
    logic [15:0] m;
    int kind, dur;

    do_reset();
    check("rst_row", {28'b0, row_out}, 32'hE);
    check("rst_code", {28'b0, key_code}, 32'h0);
    check("rst_valid", {31'b0, key_valid}, 32'h0);
    check("rst_held", {31'b0, key_held}, 32'h0);
    check("rst_val", val_out, 32'h0);
    pressed = '0;
    model_step(16'h0, acc);
    repeat (SP) @(posedge clk);
    #1;
    check("row_step", {28'b0, row_out}, 32'hD);
    repeat (FRAME - SP) @(posedge clk);
    #1;

    v0 = valid_cnt;
    repeat (5) frame(16'h0040, 1'b0);
    check("key6_pulses", valid_cnt - v0, 1);
    check("key6_code", {28'b0, key_code}, 32'h6);
    check("key6_val", val_out, 32'h6);
    repeat (2) frame(16'h0, 1'b0);
    check("key6_release", {31'b0, key_held}, 32'h0);

    v0 = valid_cnt;
    repeat (6) begin
      frame(16'h0020, 1'b0);
      frame(16'h0, 1'b0);
    end
    check("bounce_pulses", valid_cnt - v0, 0);

    v0 = valid_cnt;
    repeat (6) frame(16'h0003, 1'b0);
    check("multi_pulses", valid_cnt - v0, 0);
    check("multi_state", 32'(dut.state_q), 32'(ST_IDLE));
    frame(16'h0, 1'b0);

    foreach (kpos[k]) begin
      repeat (DF) frame(one << kpos[k], 1'b0);
      repeat (DF) frame(16'h0, 1'b0);
    end
    check("seq_val", val_out, 32'h23ABCDE0);

    frame(one << 10, 1'b0);
    frame(one << 10, 1'b1);
    repeat (2) frame(16'h0, 1'b0);
    check("clr_val", val_out, 32'h0);
    check("clr_code", {28'b0, key_code}, 32'h9);

    frame(one << 8, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    v0 = valid_cnt;
    do_reset();
    repeat (3) frame(16'h0, 1'b0);
    check("rst_db_pulses", valid_cnt - v0, 0);
    check("rst_db_code", {28'b0, key_code}, 32'h0);

    repeat (80) begin
      kind = $urandom_range(0, 99);
      dur  = $urandom_range(1, 4);
      if (kind < 40) m = 16'h0;
      else if (kind < 85) m = one << $urandom_range(0, 15);
      else begin
        m = 16'($urandom);
        if ($countones(m) < 2) m = m | 16'h0300;
      end
      repeat (dur) frame(m, 1'b0);
    end
    repeat (DF) frame(16'h0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
